seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digit positions observed.
REQ-002 Parameter SETTLE_CYCLES, default 4: consecutive stable cycles required before a digit is captured; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 an_in  input  NUM_DIGITS  digit enables, active-low; bit i selects digit i.
REQ-006 seg_in  input  7  segments, active-low; bit0=a .. bit6=g.
REQ-007 digits_out  output  4*NUM_DIGITS  decoded BCD; digit i in bits [4i+3:4i].
REQ-008 blank_mask  output  NUM_DIGITS  bit i set when digit i was captured with all segments off.
REQ-009 invalid_mask  output  NUM_DIGITS  bit i set when digit i was captured with a non-decodable pattern.
REQ-010 frame_valid  output  1  one-cycle pulse when a complete frame is presented on the outputs.

Function
REQ-011 Inputs shall be inverted internally to active-high; an_in and seg_in shall pass through one input register stage before use.
REQ-012 The decode shall map active-high gfedcba as follows: 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9; 00->blank (value F); any other pattern->invalid (value E).
REQ-013 The FSM shall have exactly three states: IDLE, SETTLE, HOLD.
REQ-014 IDLE: remain while the registered enable is not one-hot (zero digits or more than one digit active); go to SETTLE and load the settle counter with 1 on a one-hot enable.
REQ-015 SETTLE: if enable and segments both equal the previous cycle, increment the counter; otherwise reload it with 1 and stay; if the enable is no longer one-hot, go to IDLE.
REQ-016 When the counter reaches SETTLE_CYCLES, the block shall write the decoded value, blank flag and invalid flag into the slot of the active digit, set that slot's captured flag, and go to HOLD.
REQ-017 HOLD: no further capture; go to SETTLE (counter=1) on any change of enable to another one-hot value, or to IDLE on non-one-hot; a segment-only change in HOLD shall be ignored.
REQ-018 A re-capture of an already captured digit before the frame completes shall overwrite that slot.
REQ-019 When all NUM_DIGITS captured flags are set, on the next cycle: copy the slots to digits_out/blank_mask/invalid_mask, pulse frame_valid for exactly one cycle, and clear all captured flags.
REQ-020 If the frame completes in the same cycle as a new capture, the new capture shall belong to the next frame.
REQ-021 Outputs shall hold their last frame values between frame_valid pulses.
REQ-022 Latency from the first input change to capture shall be 1 (input register) + SETTLE_CYCLES cycles; from the last capture to frame_valid, 1 cycle.
REQ-023 The settle counter width shall be clog2(SETTLE_CYCLES+1) and the counter shall saturate, never wrapping.

Reset
REQ-024 While rst_n=0 at a clock edge: state=IDLE, counter=0, captured flags=0, slots=0, input registers=all-inactive, digits_out=0, blank_mask=0, invalid_mask=0, frame_valid=0.
REQ-025 Reset asserted mid-frame shall discard partial captures; the first frame_valid after reset shall require all digits to be captured anew.

Structure
REQ-026 Package seg_pkg shall hold the ten segment pattern constants, the BLANK (F) and INVALID (E) codes, and the FSM state typedef.
REQ-027 Pattern decode shall be one combinational sub-module, seg_pattern_decode (7-bit in; 4-bit value, blank, invalid out); the FSM, counter and slot storage stay in seg_scan_decoder.

Verification
REQ-028 Scan "1234" (digit0=4), each digit held 10 cycles, SETTLE_CYCLES=4 -> frame_valid once per scan, digits_out=16'h1234, masks=0.
REQ-029 Digit2 driven seg=active-high 00, digit1=7F -> digits_out[11:8]=F, blank_mask=4'b0100, digits_out[7:4]=8.
REQ-030 Digit0 driven active-high 49 -> digits_out[3:0]=E, invalid_mask=4'b0001; other digits decoded normally.
REQ-031 Segments toggled every 3 cycles with SETTLE_CYCLES=4, or two anodes active together -> no capture, no frame_valid.
REQ-032 rst_n pulsed low after three digits are captured -> no frame_valid until all four digits are captured again; outputs read 0 until then.
REQ-033 Digit held 100 cycles with a segment change in HOLD -> single capture of the original value.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-high, bit0=a .. bit6=g.
package seg_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned BCD_W = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    localparam logic [BCD_W-1:0] CODE_BLANK   = 4'hF;
    localparam logic [BCD_W-1:0] CODE_INVALID = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // One captured digit slot
    typedef struct packed {
        logic [BCD_W-1:0] value;
        logic             blank;
        logic             invalid;
    } digit_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational map from an active-high gfedcba pattern to BCD,
// flagging all-off patterns as blank and anything unrecognised as invalid.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [BCD_W-1:0] value_c_o,
    output logic             blank_c_o,
    output logic             invalid_c_o
);

    always_comb begin
        value_c_o   = CODE_INVALID;
        blank_c_o   = 1'b0;
        invalid_c_o = 1'b0;
        case (seg_i)
            SEG_0:   value_c_o = 4'd0;
            SEG_1:   value_c_o = 4'd1;
            SEG_2:   value_c_o = 4'd2;
            SEG_3:   value_c_o = 4'd3;
            SEG_4:   value_c_o = 4'd4;
            SEG_5:   value_c_o = 4'd5;
            SEG_6:   value_c_o = 4'd6;
            SEG_7:   value_c_o = 4'd7;
            SEG_8:   value_c_o = 4'd8;
            SEG_9:   value_c_o = 4'd9;
            SEG_OFF: begin
                value_c_o = CODE_BLANK;
                blank_c_o = 1'b1;
            end
            default: invalid_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Observes a multiplexed seven-segment display bus, captures each digit once it
// has been stable long enough, and publishes a complete frame of BCD digits.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic [SEG_W-1:0]        seg_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   invalid_mask,
    output logic                    frame_valid
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

    logic [NUM_DIGITS-1:0] an_q;
    logic [NUM_DIGITS-1:0] an_prev_q;
    logic [SEG_W-1:0]      seg_q;
    logic [SEG_W-1:0]      seg_prev_q;

    state_e                state_q;
    state_e                state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    logic                  an_onehot_c;
    logic                  an_changed_c;
    logic                  seg_changed_c;
    logic                  capture_c;

    logic [BCD_W-1:0]      dec_value_c;
    logic                  dec_blank_c;
    logic                  dec_invalid_c;

    digit_t [NUM_DIGITS-1:0]            slot_q;
    digit_t [NUM_DIGITS-1:0]            slot_d;
    logic   [NUM_DIGITS-1:0]            cap_q;
    logic   [NUM_DIGITS-1:0]            cap_d;
    logic   [NUM_DIGITS-1:0][BCD_W-1:0] dout_q;
    logic   [NUM_DIGITS-1:0][BCD_W-1:0] dout_d;
    logic   [NUM_DIGITS-1:0]            blank_q;
    logic   [NUM_DIGITS-1:0]            blank_d;
    logic   [NUM_DIGITS-1:0]            inv_q;
    logic   [NUM_DIGITS-1:0]            inv_d;
    logic                               fv_q;
    logic                               fv_d;

    // Input stage: invert to active-high; reset value means no digit and no segment lit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q       <= '0;
            seg_q      <= '0;
            an_prev_q  <= '0;
            seg_prev_q <= '0;
        end else begin
            an_q       <= ~an_in;
            seg_q      <= ~seg_in;
            an_prev_q  <= an_q;
            seg_prev_q <= seg_q;
        end
    end

    assign an_onehot_c   = (an_q != '0) && ((an_q & (an_q - NUM_DIGITS'(1))) == '0);
    assign an_changed_c  = (an_q != an_prev_q);
    assign seg_changed_c = (seg_q != seg_prev_q);

    seg_pattern_decode u_decode (
        .seg_i       (seg_q),
        .value_c_o   (dec_value_c),
        .blank_c_o   (dec_blank_c),
        .invalid_c_o (dec_invalid_c)
    );

    // FSM state and settle counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state; reaching the settle target promotes SETTLE straight to HOLD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (an_onehot_c) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (!an_onehot_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!an_changed_c && !seg_changed_c) begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end else begin
                    cnt_d = CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (!an_onehot_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (an_changed_c) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        if ((state_d == ST_SETTLE) && (cnt_d == CNT_MAX)) begin
            state_d = ST_HOLD;
        end
    end

    // HOLD is only entered, or re-entered after a digit switch, through a capture
    always_comb begin
        capture_c = (state_d == ST_HOLD) && ((state_q != ST_HOLD) || an_changed_c);
    end

    // Slot storage and frame publication; a capture coinciding with publication lands in the next frame
    always_comb begin
        slot_d  = slot_q;
        cap_d   = cap_q;
        dout_d  = dout_q;
        blank_d = blank_q;
        inv_d   = inv_q;
        fv_d    = 1'b0;
        if (&cap_q) begin
            fv_d  = 1'b1;
            cap_d = '0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dout_d[i]  = slot_q[i].value;
                blank_d[i] = slot_q[i].blank;
                inv_d[i]   = slot_q[i].invalid;
            end
        end
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (capture_c && an_q[i]) begin
                slot_d[i].value   = dec_value_c;
                slot_d[i].blank   = dec_blank_c;
                slot_d[i].invalid = dec_invalid_c;
                cap_d[i]          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q  <= '0;
            cap_q   <= '0;
            dout_q  <= '0;
            blank_q <= '0;
            inv_q   <= '0;
            fv_q    <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            cap_q   <= cap_d;
            dout_q  <= dout_d;
            blank_q <= blank_d;
            inv_q   <= inv_d;
            fv_q    <= fv_d;
        end
    end

    assign digits_out   = dout_q;
    assign blank_mask   = blank_q;
    assign invalid_mask = inv_q;
    assign frame_valid  = fv_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: frame table, directed corner
// sequences and random scanning, all compared against a run-length model.
module tb_seg_scan_decoder;

    localparam int unsigned ND = 4;
    localparam int unsigned NS = 4;
    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic            clk;
    logic            rst_n;
    logic [ND-1:0]   an_in;
    logic [6:0]      seg_in;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   blank_mask;
    logic [ND-1:0]   invalid_mask;
    logic            frame_valid;

    seg_scan_decoder #(.NUM_DIGITS(ND), .SETTLE_CYCLES(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .an_in        (an_in),
        .seg_in       (seg_in),
        .digits_out   (digits_out),
        .blank_mask   (blank_mask),
        .invalid_mask (invalid_mask),
        .frame_valid  (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int fv_count = 0;
    int fv0;
    int lat;

    // Reference model: a digit is captured once per enable window, when a run
    // of identical segment samples first reaches NS; the frame publishes one
    // cycle after every digit holds a capture.
    logic [3:0]    m_slot_v [ND];
    logic          m_slot_b [ND];
    logic          m_slot_i [ND];
    logic          m_cap    [ND];
    logic [3:0]    m_out_v  [ND];
    logic          m_out_b  [ND];
    logic          m_out_i  [ND];
    logic          m_fv;
    bit            m_win;
    logic [ND-1:0] m_win_an;
    logic [6:0]    m_run_seg;
    int            m_run_len;
    bit            m_done;
    bit            m_pend;
    int            m_pend_idx;
    logic [6:0]    m_pend_seg;

    typedef struct packed {
        logic [27:0] segs;     // {digit3, digit2, digit1, digit0}, active-high
        logic [15:0] digits;
        logic [3:0]  blank;
        logic [3:0]  inv;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++)
            if (s == PAT[k]) return {2'b00, 4'(k)};
        if (s == 7'h00) return {2'b10, 4'hF};
        return {2'b01, 4'hE};
    endfunction

    function automatic bit is_onehot(input logic [ND-1:0] a);
        return $countones(a) == 1;
    endfunction

    function automatic int idx_of(input logic [ND-1:0] a);
        for (int k = 0; k < int'(ND); k++)
            if (a[k]) return k;
        return 0;
    endfunction

    task automatic model_edge(input logic r, input logic [ND-1:0] an, input logic [6:0] seg);
        logic [5:0] d;
        bit all_cap;
        if (!r) begin
            for (int i = 0; i < int'(ND); i++) begin
                m_slot_v[i] = '0; m_slot_b[i] = 1'b0; m_slot_i[i] = 1'b0; m_cap[i] = 1'b0;
                m_out_v[i]  = '0; m_out_b[i]  = 1'b0; m_out_i[i]  = 1'b0;
            end
            m_fv = 1'b0; m_win = 0; m_done = 0; m_pend = 0; m_run_len = 0;
        end else begin
            m_fv = 1'b0;
            all_cap = 1;
            for (int i = 0; i < int'(ND); i++)
                if (!m_cap[i]) all_cap = 0;
            if (all_cap) begin
                m_fv = 1'b1;
                for (int i = 0; i < int'(ND); i++) begin
                    m_out_v[i] = m_slot_v[i];
                    m_out_b[i] = m_slot_b[i];
                    m_out_i[i] = m_slot_i[i];
                    m_cap[i]   = 1'b0;
                end
            end
            if (m_pend) begin
                d = ref_decode(m_pend_seg);
                m_slot_v[m_pend_idx] = d[3:0];
                m_slot_b[m_pend_idx] = d[5];
                m_slot_i[m_pend_idx] = d[4];
                m_cap[m_pend_idx]    = 1'b1;
                m_pend = 0;
            end
            if (is_onehot(an)) begin
                if (!m_win || an != m_win_an) begin
                    m_win = 1; m_win_an = an; m_run_seg = seg; m_run_len = 1; m_done = 0;
                end else if (seg == m_run_seg) begin
                    m_run_len++;
                end else begin
                    m_run_seg = seg; m_run_len = 1;
                end
                if (!m_done && m_run_len >= int'(NS)) begin
                    m_pend = 1; m_pend_idx = idx_of(an); m_pend_seg = seg; m_done = 1;
                end
            end else begin
                m_win = 0;
            end
        end
    endtask

    task automatic check_outputs();
        logic [4*ND-1:0] ed;
        logic [ND-1:0]   eb;
        logic [ND-1:0]   ei;
        for (int i = 0; i < int'(ND); i++) begin
            ed[4*i +: 4] = m_out_v[i];
            eb[i]        = m_out_b[i];
            ei[i]        = m_out_i[i];
        end
        chk("model_frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("model_digits_out", 32'(digits_out), 32'(ed));
        chk("model_blank_mask", 32'(blank_mask), 32'(eb));
        chk("model_invalid_mask", 32'(invalid_mask), 32'(ei));
        if (frame_valid === 1'b1) fv_count++;
    endtask

    // One clock: drive active-high values inverted onto the bus, sample 1 time unit after the edge
    task automatic step(input logic [ND-1:0] an_ah, input logic [6:0] seg_ah);
        an_in  = ~an_ah;
        seg_in = ~seg_ah;
        @(posedge clk);
        model_edge(rst_n, an_ah, seg_ah);
        #1;
        check_outputs();
    endtask

    task automatic hold(input int d, input logic [6:0] s, input int n);
        logic [ND-1:0] a;
        a = '0;
        a[d] = 1'b1;
        repeat (n) step(a, s);
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, 7'h00);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        an_in  = '1;
        seg_in = '1;
        do_reset(3);
        chk("reset_digits_out", 32'(digits_out), 32'h0);
        chk("reset_blank_mask", 32'(blank_mask), 32'h0);
        chk("reset_invalid_mask", 32'(invalid_mask), 32'h0);
        chk("reset_frame_valid", 32'(frame_valid), 32'h0);

        tbl[0] = '{segs: {7'h06, 7'h5B, 7'h4F, 7'h66}, digits: 16'h1234, blank: 4'b0000, inv: 4'b0000};
        tbl[1] = '{segs: {7'h3F, 7'h00, 7'h7F, 7'h6D}, digits: 16'h0F85, blank: 4'b0100, inv: 4'b0000};
        tbl[2] = '{segs: {7'h07, 7'h7D, 7'h6F, 7'h49}, digits: 16'h769E, blank: 4'b0000, inv: 4'b0001};
        tbl[3] = '{segs: {7'h6D, 7'h7D, 7'h07, 7'h7F}, digits: 16'h5678, blank: 4'b0000, inv: 4'b0000};
        tbl[4] = '{segs: {7'h6F, 7'h3F, 7'h3F, 7'h6F}, digits: 16'h9009, blank: 4'b0000, inv: 4'b0000};
        tbl[5] = '{segs: {7'h00, 7'h01, 7'h4F, 7'h00}, digits: 16'hFE3F, blank: 4'b1001, inv: 4'b0100};

        // Frame table: each digit held 10 cycles, exactly one frame per scan
        for (int t = 0; t < 6; t++) begin
            fv0 = fv_count;
            for (int d = 0; d < int'(ND); d++)
                hold(d, tbl[t].segs[7*d +: 7], 10);
            chk("tbl_frame_count", 32'(fv_count - fv0), 32'd1);
            chk("tbl_digits", 32'(digits_out), 32'(tbl[t].digits));
            chk("tbl_blank", 32'(blank_mask), 32'(tbl[t].blank));
            chk("tbl_invalid", 32'(invalid_mask), 32'(tbl[t].inv));
        end

        // Latency from the last digit appearing to frame_valid
        idle(3);
        hold(1, 7'h66, 10);
        hold(2, 7'h6D, 10);
        hold(3, 7'h7D, 10);
        lat = 0;
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            hold(0, 7'h06, 1);
            if (frame_valid === 1'b1) lat = i;
        end
        chk("last_capture_latency", 32'(lat), 32'(NS + 2));
        hold(0, 7'h06, 5);
        chk("latency_digits", 32'(digits_out), 32'h6541);

        // Long hold with a segment change after capture keeps the original value
        idle(3);
        fv0 = fv_count;
        hold(0, 7'h66, 20);
        hold(0, 7'h6F, 80);
        hold(1, 7'h06, 10);
        hold(2, 7'h5B, 10);
        hold(3, 7'h4F, 10);
        chk("hold_frame_count", 32'(fv_count - fv0), 32'd1);
        chk("hold_digits", 32'(digits_out), 32'h3214);

        // Re-capturing a digit before the frame completes overwrites its slot
        idle(3);
        fv0 = fv_count;
        hold(0, 7'h3F, 10);
        hold(1, 7'h6D, 10);
        hold(0, 7'h07, 10);
        hold(2, 7'h7D, 10);
        hold(3, 7'h7F, 10);
        chk("recapture_frame_count", 32'(fv_count - fv0), 32'd1);
        chk("recapture_digits", 32'(digits_out), 32'h8657);

        // Unsettled segments and multiple anodes never capture
        idle(3);
        fv0 = fv_count;
        hold(1, 7'h06, 10);
        hold(2, 7'h06, 10);
        hold(3, 7'h06, 10);
        for (int i = 0; i < 12; i++)
            hold(0, (i % 2 == 0) ? 7'h3F : 7'h06, 3);
        repeat (30) step(4'b0011, 7'h3F);
        repeat (30) step(4'b1001, 7'h6D);
        chk("no_capture_frame_count", 32'(fv_count - fv0), 32'd0);
        chk("no_capture_digits", 32'(digits_out), 32'h8657);
        hold(0, 7'h7F, 10);
        chk("after_glitch_frame_count", 32'(fv_count - fv0), 32'd1);
        chk("after_glitch_digits", 32'(digits_out), 32'h1118);

        // Reset mid-frame discards partial captures
        idle(3);
        hold(0, 7'h66, 10);
        hold(1, 7'h4F, 10);
        hold(2, 7'h5B, 10);
        do_reset(2);
        chk("midreset_digits", 32'(digits_out), 32'h0);
        chk("midreset_masks", 32'({blank_mask, invalid_mask}), 32'h0);
        fv0 = fv_count;
        hold(3, 7'h06, 20);
        chk("midreset_no_frame", 32'(fv_count - fv0), 32'd0);
        chk("midreset_digits_hold", 32'(digits_out), 32'h0);
        hold(0, 7'h66, 10);
        hold(1, 7'h4F, 10);
        hold(2, 7'h5B, 10);
        idle(2);
        chk("midreset_frame", 32'(fv_count - fv0), 32'd1);
        chk("midreset_new_digits", 32'(digits_out), 32'h1234);

        // Random scanning against the model
        for (int n = 0; n < 500; n++) begin
            logic [ND-1:0] a;
            logic [6:0]    s;
            int            len;
            int            pick;
            int            glitch_at;
            if ($urandom_range(0, 99) < 85) begin
                a = '0;
                a[$urandom_range(0, ND - 1)] = 1'b1;
            end else begin
                a = ND'($urandom);
            end
            pick = int'($urandom_range(0, 12));
            if (pick < 10) s = PAT[pick];
            else if (pick == 10) s = 7'h00;
            else s = 7'($urandom);
            len = int'($urandom_range(1, 12));
            glitch_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 11)) : -1;
            for (int c = 0; c < len; c++)
                step(a, (c == glitch_at) ? s ^ 7'h01 : s);
            if ($urandom_range(0, 199) == 0) do_reset(2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
